rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Write-port controller for the 16 x 8-bit CPU register file. After reset it sequences a clear sweep that writes INIT_VAL into every register. It then arbitrates two writeback requesters onto the file's single write port: A is the ALU/execute writeback and B is the load/memory writeback. It drives the register file's write controls from registers, so every accepted write reaches the file exactly one cycle after acceptance.

## Interface
Parameters:
- CLEAR_EN, 1: 1 runs the post-reset clear sweep; 0 goes straight to RUN.
- INIT_VAL, 8'h00: value written to every register during the sweep.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  synchronous, active-low reset, sampled on posedge CLK.
- hold  in  1  high blocks all new grants in RUN; the staged write still drains.
- a_vld  in  1  requester A has a write pending.
- a_reg  in  4  A destination register.
- a_dat  in  8  A write data.
- a_rdy  out  1  A accepted this cycle (combinational).
- b_vld  in  1  requester B has a write pending.
- b_reg  in  4  B destination register.
- b_dat  in  8  B write data.
- b_rdy  out  1  B accepted this cycle (combinational).
- wrt_en  out  1  register-file write enable (registered).
- reg_wrt  out  4  register-file write address (registered).
- wrt_dat  out  8  register-file write data (registered).
- init_done  out  1  high once the block is in RUN (registered).

## Operation
- States:
  - INIT: clear sweep. Entered on reset when CLEAR_EN=1.
  - RUN: arbitration. Entered on reset when CLEAR_EN=0, and from INIT when the counter reaches 15.
- 4-bit counter cnt, used only in INIT.
- INIT, each cycle:
  - stage wrt_en=1, reg_wrt=cnt, wrt_dat=INIT_VAL, then cnt++.
  - when cnt==15, next state is RUN.
  - a_rdy and b_rdy are 0 and requests are ignored.
- RUN arbitration:
  - eligible = vld & ~hold.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, round-robin picks the requester not granted last. last_grant updates only on an actual grant. Reset value is B, so A wins the first conflict.
- Acceptance:
  - A grant is a_rdy (or b_rdy) = 1. The request is accepted when vld and rdy are both high in the same cycle.
  - Accepted reg/dat go to the output registers with wrt_en=1.
  - With no grant in a cycle, wrt_en=0 next cycle and reg_wrt/wrt_dat hold their values.
- Throughput: one write per cycle. The register file never back-pressures.
- rdy must never be asserted while vld=0.
- Same destination: A and B targeting the same register are still serialized in round-robin order. The later grant's data is what remains in the register.
- Requesters must hold reg/dat stable while vld=1 and rdy=0.
- Reset mid-operation:
  - the next edge with RST_N=0 drops any staged write (wrt_en=0) and restarts INIT from cnt=0.
  - last_grant returns to B.

## Timing
- Reset values: wrt_en=0, reg_wrt=0, wrt_dat=0, init_done=0, cnt=0, last_grant=B. a_rdy and b_rdy read 0 while RST_N=0.
- Sweep (CLEAR_EN=1):
  - E0 is the first posedge with RST_N=1.
  - After edge Ek (k=0..15): wrt_en=1, reg_wrt=k, wrt_dat=INIT_VAL.
  - After E15: state=RUN and init_done=1.
  - Grants are possible in the cycle after E15.
  - The write to r15 is presented during that same cycle, and a write granted then reaches the register file one cycle later.
- CLEAR_EN=0: after E0, state=RUN and init_done=1. No sweep writes occur.
- Latency:
  - request accepted in cycle N gives wrt_en/reg_wrt/wrt_dat valid in cycle N+1.
  - the register is updated at the posedge ending cycle N+1.
- hold: takes effect combinationally in the same cycle and blocks a grant in that cycle. It does not cancel an already-staged write.

## Test plan
- Reset and sweep: CLEAR_EN=1, INIT_VAL=8'hA5, RST_N low for 2 cycles then high. Required: 16 consecutive writes r0..r15 of A5, init_done high after E15, and rdy low throughout INIT even with a_vld=1.
- Single requester: in RUN, a_vld with a_reg=3, a_dat=8'h31 for one cycle. Required: a_rdy=1 the same cycle, then wrt_en=1, reg_wrt=3, wrt_dat=31 the next cycle, then wrt_en=0.
- Round-robin: A and B both valid continuously, each with different data. Required: grants alternate A,B,A,B with A first after reset, and one write per cycle.
- Same-register conflict: A (r5, 8'h11) and B (r5, 8'h22) valid together from the first RUN cycle. Required: A is written, then B, and r5 finally holds 8'h22.
- hold: both requesters valid with hold=1 for 3 cycles. Required: rdy=0 and wrt_en=0 after the staged write drains. On hold release, arbitration resumes with the correct round-robin owner.
- Mid-operation reset: assert RST_N=0 for one edge while writes stream. Required: wrt_en=0 and init_done=0 after that edge, and the sweep restarts at r0.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register-file write-port controller: post-reset clear sweep, then A/B writeback arbitration
module rf_wr_arbiter #(
  parameter bit         CLEAR_EN = 1'b1,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       hold,
  input  logic       a_vld,
  input  logic [3:0] a_reg,
  input  logic [7:0] a_dat,
  output logic       a_rdy,
  input  logic       b_vld,
  input  logic [3:0] b_reg,
  input  logic [7:0] b_dat,
  output logic       b_rdy,
  output logic       wrt_en,
  output logic [3:0] reg_wrt,
  output logic [7:0] wrt_dat,
  output logic       init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_b;
  logic       a_elig;
  logic       b_elig;
  logic       in_run;

  assign a_elig = a_vld & ~hold;
  assign b_elig = b_vld & ~hold;
  assign in_run = RST_N & (state == ST_RUN);

  // On a conflict the requester not granted last wins.
  assign a_rdy = in_run & a_elig & (~b_elig | last_b);
  assign b_rdy = in_run & b_elig & (~a_elig | ~last_b);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_INIT;
      cnt       <= 4'd0;
      last_b    <= 1'b1;
      wrt_en    <= 1'b0;
      reg_wrt   <= 4'd0;
      wrt_dat   <= 8'd0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      if (!CLEAR_EN) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
        wrt_en    <= 1'b0;
      end else begin
        wrt_en  <= 1'b1;
        reg_wrt <= cnt;
        wrt_dat <= INIT_VAL;
        cnt     <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end
    end else begin
      if (a_rdy) begin
        wrt_en  <= 1'b1;
        reg_wrt <= a_reg;
        wrt_dat <= a_dat;
        last_b  <= 1'b0;
      end else if (b_rdy) begin
        wrt_en  <= 1'b1;
        reg_wrt <= b_reg;
        wrt_dat <= b_dat;
        last_b  <= 1'b1;
      end else begin
        wrt_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - randomized bench for rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;

  logic       CLK, RST_N, hold;
  logic       a_vld, b_vld;
  logic [3:0] a_reg, b_reg;
  logic [7:0] a_dat, b_dat;
  logic       a_rdy, b_rdy, wrt_en, init_done;
  logic [3:0] reg_wrt;
  logic [7:0] wrt_dat;
  logic       a_rdy1, b_rdy1, wrt_en1, init_done1;
  logic [3:0] reg_wrt1;
  logic [7:0] wrt_dat1;

  rf_wr_arbiter #(.CLEAR_EN(1'b1), .INIT_VAL(8'hA5)) dut (
    .CLK(CLK), .RST_N(RST_N), .hold(hold),
    .a_vld(a_vld), .a_reg(a_reg), .a_dat(a_dat), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_reg(b_reg), .b_dat(b_dat), .b_rdy(b_rdy),
    .wrt_en(wrt_en), .reg_wrt(reg_wrt), .wrt_dat(wrt_dat), .init_done(init_done)
  );

  rf_wr_arbiter #(.CLEAR_EN(1'b0), .INIT_VAL(8'h3C)) dut_nc (
    .CLK(CLK), .RST_N(RST_N), .hold(hold),
    .a_vld(a_vld), .a_reg(a_reg), .a_dat(a_dat), .a_rdy(a_rdy1),
    .b_vld(b_vld), .b_reg(b_reg), .b_dat(b_dat), .b_rdy(b_rdy1),
    .wrt_en(wrt_en1), .reg_wrt(reg_wrt1), .wrt_dat(wrt_dat1), .init_done(init_done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The register file the DUT drives.
  logic [7:0] rf [16];
  always @(posedge CLK) if (wrt_en) rf[reg_wrt] <= wrt_dat;

  int total = 0;
  int bad = 0;

  // Behavioural model state.
  logic       m_run, m_last_b, m_en, m_done;
  logic [3:0] m_reg;
  logic [7:0] m_dat;
  int         m_cnt;
  logic [1:0] m_g;
  logic [1:0] eg;

  // Bit 0 = grant A, bit 1 = grant B.
  function automatic logic [1:0] exp_grant();
    logic ea, eb;
    ea = a_vld && !hold;
    eb = b_vld && !hold;
    if (!RST_N || m_run !== 1'b1) return 2'b00;
    if (ea && eb) return m_last_b ? 2'b01 : 2'b10;
    return {eb, ea};
  endfunction

  task tick();
    m_g = exp_grant();
    @(posedge CLK);
    if (!RST_N) begin
      m_run = 0; m_cnt = 0; m_last_b = 1; m_en = 0; m_reg = 0; m_dat = 0; m_done = 0;
    end else if (!m_run) begin
      m_en = 1; m_reg = m_cnt[3:0]; m_dat = 8'hA5;
      if (m_cnt == 15) begin m_run = 1; m_done = 1; end
      m_cnt = (m_cnt + 1) % 16;
    end else if (m_g[0]) begin
      m_en = 1; m_reg = a_reg; m_dat = a_dat; m_last_b = 0;
    end else if (m_g[1]) begin
      m_en = 1; m_reg = b_reg; m_dat = b_dat; m_last_b = 1;
    end else begin
      m_en = 0;
    end
    #1;
  endtask

  task test_reset();
    RST_N = 0; hold = 0; a_vld = 1; a_reg = 4'd7; a_dat = 8'h77;
    b_vld = 0; b_reg = 0; b_dat = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({b_rdy, a_rdy, b_rdy1, a_rdy1} !== 4'b0000) begin bad++; $display("FAIL reset_rdy got %b want 0000", {b_rdy, a_rdy, b_rdy1, a_rdy1}); end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat, init_done} !== 14'd0) begin bad++; $display("FAIL reset_out got %b/%0d/%h/%b want all zero", wrt_en, reg_wrt, wrt_dat, init_done); end
    end
    RST_N = 1;
    for (int k = 0; k < 16; k++) begin
      #1;
      total++; if ({b_rdy, a_rdy} !== 2'b00) begin bad++; $display("FAIL sweep_rdy k=%0d got %b want 00", k, {b_rdy, a_rdy}); end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat, init_done} !== {1'b1, 4'(k), 8'hA5, (k == 15)}) begin bad++; $display("FAIL sweep_out k=%0d got %b/%0d/%h/%b want 1/%0d/a5/%b", k, wrt_en, reg_wrt, wrt_dat, init_done, k, k == 15); end
      if (k == 0) begin
        total++; if ({init_done1, wrt_en1} !== 2'b10) begin bad++; $display("FAIL noclear_e0 got done=%b en=%b want done=1 en=0", init_done1, wrt_en1); end
      end
    end
  endtask

  task test_same_reg();
    a_vld = 1; a_reg = 4'd5; a_dat = 8'h11;
    b_vld = 1; b_reg = 4'd5; b_dat = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      eg = exp_grant();
      total++; if ({b_rdy, a_rdy} !== eg) begin bad++; $display("FAIL same_rdy i=%0d got %b want %b", i, {b_rdy, a_rdy}, eg); end
      if (i < 2) begin
        total++; if ({b_rdy, a_rdy} !== ((i == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL same_order i=%0d got %b", i, {b_rdy, a_rdy}); end
      end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat, init_done} !== {m_en, m_reg, m_dat, m_done}) begin bad++; $display("FAIL same_out i=%0d got %b/%0d/%h/%b want %b/%0d/%h/%b", i, wrt_en, reg_wrt, wrt_dat, init_done, m_en, m_reg, m_dat, m_done); end
      if (m_g[0]) a_vld = 0;
      if (m_g[1]) b_vld = 0;
    end
    total++; if (rf[5] !== 8'h22) begin bad++; $display("FAIL same_final r5 got %h want 22", rf[5]); end
    total++; if ({rf[0], rf[15]} !== 16'hA5A5) begin bad++; $display("FAIL sweep_rf r0/r15 got %h/%h want a5/a5", rf[0], rf[15]); end
  endtask

  task test_single();
    a_vld = 1; a_reg = 4'd3; a_dat = 8'h31;
    #1;
    total++; if ({b_rdy, a_rdy} !== 2'b01) begin bad++; $display("FAIL single_rdy got %b want 01", {b_rdy, a_rdy}); end
    tick();
    a_vld = 0;
    total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b1, 4'd3, 8'h31}) begin bad++; $display("FAIL single_out got %b/%0d/%h want 1/3/31", wrt_en, reg_wrt, wrt_dat); end
    #1;
    tick();
    total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b0, 4'd3, 8'h31}) begin bad++; $display("FAIL single_idle got %b/%0d/%h want 0/3/31", wrt_en, reg_wrt, wrt_dat); end
  endtask

  task test_hold();
    a_vld = 1; a_reg = 4'd9; a_dat = 8'($urandom);
    #1;
    tick();
    a_reg = 4'd10; a_dat = 8'($urandom);
    b_vld = 1; b_reg = 4'd11; b_dat = 8'($urandom);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({b_rdy, a_rdy, wrt_en} !== {2'b00, (i == 0)}) begin bad++; $display("FAIL hold_rdy i=%0d got rdy=%b en=%b want rdy=00 en=%b", i, {b_rdy, a_rdy}, wrt_en, i == 0); end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b0, m_reg, m_dat}) begin bad++; $display("FAIL hold_out i=%0d got %b/%0d/%h want 0/%0d/%h", i, wrt_en, reg_wrt, wrt_dat, m_reg, m_dat); end
    end
    hold = 0;
    #1;
    total++; if ({b_rdy, a_rdy} !== 2'b10) begin bad++; $display("FAIL hold_release got %b want 10", {b_rdy, a_rdy}); end
    tick();
    total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b1, 4'd11, b_dat}) begin bad++; $display("FAIL hold_release_out got %b/%0d/%h want 1/11/%h", wrt_en, reg_wrt, wrt_dat, b_dat); end
    b_dat = 8'($urandom); b_reg = 4'($urandom_range(0, 15));
  endtask

  task test_round_robin();
    logic [1:0] prev;
    a_vld = 1; b_vld = 1; prev = 2'b10;
    for (int i = 0; i < 12; i++) begin
      #1;
      eg = exp_grant();
      total++; if ({b_rdy, a_rdy} !== eg || {b_rdy, a_rdy} === prev) begin bad++; $display("FAIL rr_grant i=%0d got %b want %b prev %b", i, {b_rdy, a_rdy}, eg, prev); end
      prev = {b_rdy, a_rdy};
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b1, m_reg, m_dat}) begin bad++; $display("FAIL rr_out i=%0d got %b/%0d/%h want 1/%0d/%h", i, wrt_en, reg_wrt, wrt_dat, m_reg, m_dat); end
      if (m_g[0]) begin a_reg = 4'($urandom_range(0, 15)); a_dat = 8'($urandom); end
      if (m_g[1]) begin b_reg = 4'($urandom_range(0, 15)); b_dat = 8'($urandom); end
    end
  endtask

  task test_random();
    for (int i = 0; i < 300; i++) begin
      if (!a_vld || m_g[0]) begin a_vld = 1'($urandom_range(0, 1)); a_reg = 4'($urandom_range(0, 15)); a_dat = 8'($urandom); end
      if (!b_vld || m_g[1]) begin b_vld = 1'($urandom_range(0, 1)); b_reg = 4'($urandom_range(0, 15)); b_dat = 8'($urandom); end
      hold = ($urandom_range(0, 3) == 0);
      #1;
      eg = exp_grant();
      total++; if ({b_rdy, a_rdy} !== eg) begin bad++; $display("FAIL rand_rdy i=%0d got %b want %b", i, {b_rdy, a_rdy}, eg); end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat, init_done} !== {m_en, m_reg, m_dat, m_done}) begin bad++; $display("FAIL rand_out i=%0d got %b/%0d/%h/%b want %b/%0d/%h/%b", i, wrt_en, reg_wrt, wrt_dat, init_done, m_en, m_reg, m_dat, m_done); end
    end
    hold = 0;
  endtask

  task test_midreset();
    a_vld = 1; b_vld = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tick();
      if (m_g[0]) a_dat = 8'($urandom);
      if (m_g[1]) b_dat = 8'($urandom);
    end
    total++; if (wrt_en !== 1'b1) begin bad++; $display("FAIL mid_stream got en=%b want 1", wrt_en); end
    RST_N = 0;
    #1;
    total++; if ({b_rdy, a_rdy} !== 2'b00) begin bad++; $display("FAIL mid_rst_rdy got %b want 00", {b_rdy, a_rdy}); end
    tick();
    total++; if ({wrt_en, init_done} !== 2'b00) begin bad++; $display("FAIL mid_rst_out got en=%b done=%b want 0/0", wrt_en, init_done); end
    RST_N = 1;
    for (int k = 0; k < 16; k++) begin
      #1;
      total++; if ({b_rdy, a_rdy} !== 2'b00) begin bad++; $display("FAIL resweep_rdy k=%0d got %b want 00", k, {b_rdy, a_rdy}); end
      tick();
      total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b1, 4'(k), 8'hA5}) begin bad++; $display("FAIL resweep_out k=%0d got %b/%0d/%h want 1/%0d/a5", k, wrt_en, reg_wrt, wrt_dat, k); end
    end
    #1;
    total++; if ({b_rdy, a_rdy} !== 2'b01) begin bad++; $display("FAIL mid_first_a got %b want 01", {b_rdy, a_rdy}); end
    tick();
    #1;
    total++; if ({b_rdy, a_rdy} !== 2'b10) begin bad++; $display("FAIL mid_then_b got %b want 10", {b_rdy, a_rdy}); end
    tick();
    total++; if ({wrt_en, reg_wrt, wrt_dat} !== {1'b1, b_reg, b_dat}) begin bad++; $display("FAIL mid_b_out got %b/%0d/%h want 1/%0d/%h", wrt_en, reg_wrt, wrt_dat, b_reg, b_dat); end
  endtask

  initial begin
    m_g = 2'b00;
    test_reset();
    test_same_reg();
    test_single();
    test_hold();
    test_round_robin();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
